// File: rtl/packet_injector.sv
// packet_injector: turns one offered packet (x/y destination plus two data
// words) into a head/body/body/tail flit stream towards a router input port.
// The flit in flight is held until the router acks it. A new packet may be
// accepted on the same edge the tail is acked, so the next head follows the
// tail with no idle cycle in between.
module packet_injector #(
  parameter int FLIT_SIZE    = 19,
  parameter int NUM_OF_FLITS = 4,
  parameter int ADDR_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [ADDR_BITS-1:0] dst_x_i,
  input  logic [ADDR_BITS-1:0] dst_y_i,
  input  logic [FLIT_SIZE-4:0] data0_i,
  input  logic [FLIT_SIZE-4:0] data1_i,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 downstream_req_o,
  input  logic                 downstream_ack_i,
  output logic                 busy_o,
  output logic                 pkt_sent_o,
  output logic [15:0]          pkt_count_o
);

  localparam int DATA_W = FLIT_SIZE - 3;
  localparam int PTR_W  = (NUM_OF_FLITS > 1) ? $clog2(NUM_OF_FLITS) : 1;

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b01;
  localparam logic [1:0] TYPE_NONE = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_ptr;
  logic [ADDR_BITS-1:0] r_dst_x;
  logic [ADDR_BITS-1:0] r_dst_y;
  logic [DATA_W-1:0]    r_data0;
  logic [DATA_W-1:0]    r_data1;
  logic                 r_pkt_sent;
  logic [15:0]          r_pkt_count;

  logic w_active;
  logic w_last;
  logic w_xfer;
  logic w_tail_xfer;
  logic w_ready;
  logic w_accept;

  assign w_active    = (r_state == ACTIVE);
  assign w_last      = (r_ptr == PTR_W'(NUM_OF_FLITS - 1));
  assign w_xfer      = w_active && downstream_ack_i;
  assign w_tail_xfer = w_xfer && w_last;
  // Ready is combinational on the ack so a packet can be taken over the tail edge.
  assign w_ready     = !w_active || w_tail_xfer;
  assign w_accept    = pkt_valid_i && w_ready;

  assign pkt_ready_o      = w_ready;
  assign downstream_req_o = w_active;
  assign busy_o           = w_active;
  assign pkt_sent_o       = r_pkt_sent;
  assign pkt_count_o      = r_pkt_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave ACTIVE only when the tail goes out and nothing replaces it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_state_nxt = ACTIVE;
      ACTIVE: if (w_tail_xfer && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flit pointer: restart on capture, otherwise step on each accepted flit.
  always_ff @(posedge clk) begin
    if (rst)           r_ptr <= '0;
    else if (w_accept) r_ptr <= '0;
    else if (w_xfer)   r_ptr <= r_ptr + PTR_W'(1);
  end

  // Packet fields, sampled only on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst_x <= '0;
      r_dst_y <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else if (w_accept) begin
      r_dst_x <= dst_x_i;
      r_dst_y <= dst_y_i;
      r_data0 <= data0_i;
      r_data1 <= data1_i;
    end
  end

  // Completion pulse and wrapping packet counter, both driven by the tail edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_sent  <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_pkt_sent <= w_tail_xfer;
      if (w_tail_xfer) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  // Flit encoding from state, pointer and captured fields.
  always_comb begin
    flit_o = {1'b0, TYPE_NONE, {DATA_W{1'b0}}};
    if (w_active) begin
      if (r_ptr == '0)
        flit_o = {1'b1, TYPE_HEAD, r_dst_x, r_dst_y};
      else if (w_last)
        flit_o = {1'b1, TYPE_TAIL, {DATA_W{1'b0}}};
      else if (r_ptr == PTR_W'(1))
        flit_o = {1'b1, TYPE_BODY, r_data0};
      else
        flit_o = {1'b1, TYPE_BODY, r_data1};
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: a queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_packet_injector;

  logic        clk;
  logic        rst;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [7:0]  dst_x_i;
  logic [7:0]  dst_y_i;
  logic [15:0] data0_i;
  logic [15:0] data1_i;
  logic [18:0] flit_o;
  logic        downstream_req_o;
  logic        downstream_ack_i;
  logic        busy_o;
  logic        pkt_sent_o;
  logic [15:0] pkt_count_o;

  int unsigned tests;
  int unsigned fails;

  packet_injector #(
    .FLIT_SIZE   (19),
    .NUM_OF_FLITS(4),
    .ADDR_BITS   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pkt_valid_i     (pkt_valid_i),
    .pkt_ready_o     (pkt_ready_o),
    .dst_x_i         (dst_x_i),
    .dst_y_i         (dst_y_i),
    .data0_i         (data0_i),
    .data1_i         (data1_i),
    .flit_o          (flit_o),
    .downstream_req_o(downstream_req_o),
    .downstream_ack_i(downstream_ack_i),
    .busy_o          (busy_o),
    .pkt_sent_o      (pkt_sent_o),
    .pkt_count_o     (pkt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Remaining flits of the packet in flight; empty queue means idle.
  logic [18:0] m_q[$];
  logic        m_active;
  logic        m_sent;
  logic [15:0] m_count;
  logic        m_valid;

  function automatic logic [18:0] mk(input logic [1:0] t, input logic [15:0] d);
    return {1'b1, t, d};
  endfunction

  initial m_valid = 1'b0;

  always @(negedge clk) begin
    logic        exp_ready;
    logic [18:0] exp_flit;
    logic        tail;
    exp_ready = !m_active || (m_q.size() == 1 && downstream_ack_i);
    exp_flit  = m_active ? m_q[0] : 19'h30000;
    if (m_valid) begin
      chk("m_ready", pkt_ready_o,      exp_ready);
      chk("m_req",   downstream_req_o, m_active);
      chk("m_busy",  busy_o,           m_active);
      chk("m_flit",  flit_o,           exp_flit);
      chk("m_sent",  pkt_sent_o,       m_sent);
      chk("m_count", pkt_count_o,      m_count);
    end
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_sent   = 1'b0;
      m_count  = 16'h0000;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      tail = 1'b0;
      if (m_active && downstream_ack_i) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          tail    = 1'b1;
          m_count = m_count + 16'd1;
        end
      end
      m_sent = tail;
      if (pkt_valid_i && exp_ready) begin
        m_q.delete();
        m_q.push_back(mk(2'b00, {dst_x_i, dst_y_i}));
        m_q.push_back(mk(2'b10, data0_i));
        m_q.push_back(mk(2'b10, data1_i));
        m_q.push_back(mk(2'b01, 16'h0000));
        m_active = 1'b1;
      end else if (m_q.size() == 0) begin
        m_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] d0, input logic [15:0] d1);
    pkt_valid_i = 1'b1;
    dst_x_i     = x;
    dst_y_i     = y;
    data0_i     = d0;
    data1_i     = d1;
  endtask

  task automatic idle_wait();
    pkt_valid_i      = 1'b0;
    downstream_ack_i = 1'b1;
    repeat (6) step();
  endtask

  logic [18:0] exp36[4];

  initial begin
    tests = 0;
    fails = 0;
    exp36[0] = 19'h40305;
    exp36[1] = 19'h6ABCD;
    exp36[2] = 19'h61234;
    exp36[3] = 19'h50000;

    rst = 1'b1;
    pkt_valid_i = 1'b0;
    downstream_ack_i = 1'b0;
    dst_x_i = '0;
    dst_y_i = '0;
    data0_i = '0;
    data1_i = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", pkt_ready_o, 1'b1);
    chk("rst_flit",  flit_o, 19'h30000);
    chk("rst_req",   downstream_req_o, 1'b0);
    chk("rst_count", pkt_count_o, 16'h0000);
    step();

    // Basic packet with ack held high.
    offer(8'h03, 8'h05, 16'hABCD, 16'h1234);
    downstream_ack_i = 1'b1;
    step();
    pkt_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("basic_flit", flit_o, exp36[i]);
    end
    @(negedge clk);
    chk("basic_sent",  pkt_sent_o, 1'b1);
    chk("basic_count", pkt_count_o, 16'd1);
    idle_wait();

    // Backpressure on body1.
    offer(8'h03, 8'h05, 16'hABCD, 16'h1234);
    downstream_ack_i = 1'b0;
    step();
    pkt_valid_i = 1'b0;
    downstream_ack_i = 1'b1;
    @(negedge clk);
    chk("bp_head", flit_o, 19'h40305);
    step();
    downstream_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_flit", flit_o, 19'h6ABCD);
      chk("bp_hold_req",  downstream_req_o, 1'b1);
      step();
    end
    downstream_ack_i = 1'b1;
    @(negedge clk);
    chk("bp_last_hold", flit_o, 19'h6ABCD);
    step();
    @(negedge clk);
    chk("bp_body2", flit_o, 19'h61234);
    idle_wait();

    // Back-to-back packets over the tail edge.
    offer(8'h11, 8'h22, 16'h0001, 16'h0002);
    downstream_ack_i = 1'b1;
    step();
    pkt_valid_i = 1'b0;
    step();
    step();
    step();
    offer(8'h44, 8'h66, 16'hBEEF, 16'hCAFE);
    @(negedge clk);
    chk("b2b_ready", pkt_ready_o, 1'b1);
    chk("b2b_tail",  flit_o, 19'h50000);
    step();
    pkt_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_head", flit_o, 19'h44466);
    chk("b2b_req",  downstream_req_o, 1'b1);
    chk("b2b_sent", pkt_sent_o, 1'b1);
    idle_wait();

    // Reset with pointer at body2.
    offer(8'h03, 8'h05, 16'hABCD, 16'h1234);
    downstream_ack_i = 1'b1;
    step();
    pkt_valid_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_body2", flit_o, 19'h61234);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req",   downstream_req_o, 1'b0);
    chk("mid_rst_flit",  flit_o, 19'h30000);
    chk("mid_rst_count", pkt_count_o, 16'h0000);
    chk("mid_rst_ready", pkt_ready_o, 1'b1);
    step();

    // Ack toggling while idle.
    pkt_valid_i = 1'b0;
    downstream_ack_i = 1'b1;
    step();
    downstream_ack_i = 1'b0;
    step();
    downstream_ack_i = 1'b1;
    step();
    downstream_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_ack_sent", pkt_sent_o, 1'b0);
    chk("idle_ack_busy", busy_o, 1'b0);
    step();

    // Counter wrap from FFFF.
    force dut.r_pkt_count = 16'hFFFF;
    m_count = 16'hFFFF;
    step();
    release dut.r_pkt_count;
    step();
    offer(8'h01, 8'h02, 16'h0003, 16'h0004);
    downstream_ack_i = 1'b1;
    step();
    pkt_valid_i = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("wrap_sent",  pkt_sent_o, 1'b1);
    chk("wrap_count", pkt_count_o, 16'h0000);
    idle_wait();

    // Randomized traffic against the model.
    repeat (4000) begin
      pkt_valid_i      = ($urandom_range(0, 1) == 1);
      downstream_ack_i = ($urandom_range(0, 9) < 7);
      dst_x_i          = 8'($urandom);
      dst_y_i          = 8'($urandom);
      data0_i          = 16'($urandom);
      data1_i          = 16'($urandom);
      rst              = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    idle_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 19, giving the flit width: {valid[18], type[17:16], data[15:0]}.
REQ-002 SHALL have parameter NUM_OF_FLITS, default 4, giving flits per packet (head, body1, body2, tail).
REQ-003 SHALL have parameter ADDR_BITS, default 8, giving the width of each of xaddr and yaddr.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pkt_valid_i, input, 1 bit: the source offers a packet.
REQ-007 SHALL have port pkt_ready_o, output, 1 bit: the injector accepts the offered packet this cycle.
REQ-008 SHALL have port dst_x_i, input, 8 bits: destination xaddr.
REQ-009 SHALL have port dst_y_i, input, 8 bits: destination yaddr.
REQ-010 SHALL have ports data0_i and data1_i, input, 16 bits each: body1 and body2 payloads.
REQ-011 SHALL have port flit_o, output, 19 bits: the flit presented to the router input port.
REQ-012 SHALL have port downstream_req_o, output, 1 bit: flit_o is valid and requests transfer.
REQ-013 SHALL have port downstream_ack_i, input, 1 bit: the router accepts flit_o this cycle.
REQ-014 SHALL have port busy_o, output, 1 bit: high while a packet is being sent.
REQ-015 SHALL have port pkt_sent_o, output, 1 bit: one-cycle pulse after the tail transfer.
REQ-016 SHALL have port pkt_count_o, output, 16 bits: number of completed packets, wrapping.

Function
REQ-017 SHALL implement FSM states IDLE and ACTIVE, plus a 2-bit flit pointer (0=head, 1=body1, 2=body2, 3=tail).
REQ-018 SHALL drive pkt_ready_o as (state==IDLE) or (state==ACTIVE, pointer==3, downstream_ack_i==1).
REQ-019 SHALL capture dst_x_i, dst_y_i, data0_i and data1_i on an edge where pkt_valid_i and pkt_ready_o are both high, then enter ACTIVE with pointer 0.
REQ-020 SHALL hold downstream_req_o high throughout ACTIVE and low in IDLE.
REQ-021 SHALL treat a flit as transferred on any edge where downstream_req_o and downstream_ack_i are both high.
REQ-022 SHALL keep flit_o stable while downstream_req_o is high and downstream_ack_i is low.
REQ-023 SHALL encode flit_o in ACTIVE as follows:
- head = {1, 2'b00, x, y}
- body = {1, 2'b10, data}
- tail = {1, 2'b01, 16'h0000}
REQ-024 SHALL drive flit_o = 19'h30000 (valid 0, type NONE) in IDLE.
REQ-025 SHALL increment the pointer by 1 on each transfer with pointer < 3.
REQ-026 SHALL, on tail transfer without a new capture, go to IDLE, pulse pkt_sent_o next cycle, and increment pkt_count_o.
REQ-027 SHALL, on tail transfer with a simultaneous capture, stay ACTIVE with pointer 0 and the new packet's fields, so the next packet's head is presented the next cycle with no bubble; pkt_sent_o and pkt_count_o still update.
REQ-028 SHALL have a latency of one cycle from the accept edge to downstream_req_o high, and take exactly 4 transfer edges when downstream_ack_i is held high.
REQ-029 SHALL ignore downstream_ack_i while in IDLE.
REQ-030 SHALL ignore pkt_valid_i while pkt_ready_o is low; no field is resampled.
REQ-031 SHALL wrap pkt_count_o from 16'hFFFF to 16'h0000.
REQ-032 SHALL drive busy_o equal to (state==ACTIVE).

Reset
REQ-033 SHALL, on rst high at a clock edge, set the following regardless of state:
- state IDLE, pointer 0
- flit_o 19'h30000
- downstream_req_o 0, busy_o 0, pkt_sent_o 0, pkt_count_o 0
- captured fields 0
REQ-034 SHALL make pkt_ready_o 1 in the first cycle after reset deasserts.
REQ-035 SHALL drop a packet in flight when reset occurs mid-operation, emit no tail, and not count it.

Verification
REQ-036 SHALL cover this scenario:
- stimulus: x=8'h03, y=8'h05, d0=16'hABCD, d1=16'h1234, ack held 1
- required response: flits 0x40305, 0x6ABCD, 0x61234, 0x50000 on 4 consecutive cycles; then pkt_sent_o pulses and pkt_count_o = 1.
REQ-037 SHALL cover this scenario:
- stimulus: ack low for 3 cycles during body1
- required response: flit_o holds 0x6ABCD with req high; the pointer advances only on the ack edge.
REQ-038 SHALL cover this scenario:
- stimulus: a second packet offered while the tail is acked
- required response: pkt_ready_o is high that cycle; the next cycle shows the new head with no idle gap.
REQ-039 SHALL cover this scenario:
- stimulus: rst asserted while pointer==2
- required response: next cycle req=0, flit_o=0x30000, pkt_count_o unchanged-to-0, pkt_ready_o=1.
REQ-040 SHALL cover this scenario:
- stimulus: 65536 packets, or pkt_count_o forced to 16'hFFFF
- required response: after one more packet pkt_count_o = 0.
REQ-041 SHALL cover this scenario:
- stimulus: ack pulsed while IDLE
- required response: no state change, no pulse on pkt_sent_o.
